// File: rtl/handshake_fork_1_pkg.sv
// Shared constants for the eager fork: default payload width and the
// largest supported fan-out.
package handshake_fork_1_pkg;

   localparam int unsigned DEFAULT_DATA_TYPE = 32;
   localparam int unsigned SIZE_MAX          = 32;

endpackage

// File: rtl/handshake_fork_1_register_block.sv
// One output leg of the eager fork: the pending flag for that consumer,
// its valid qualification, and its stall contribution.
module eager_fork_register_block (
   input  logic clk,
   input  logic rst,
   input  logic ins_valid_i,
   input  logic ins_ready_i,
   input  logic out_ready_i,
   output logic out_valid_o,
   output logic stall_o
);

   logic pending_q;
   logic pending_d;

   assign out_valid_o = ins_valid_i & pending_q;
   assign stall_o     = pending_q & ~out_ready_i;

   // Re-arm on token completion; otherwise drop once this leg has accepted.
   always_comb begin
      pending_d = pending_q;
      if (ins_valid_i) begin
         if (ins_ready_i) begin
            pending_d = 1'b1;
         end else if (out_valid_o && out_ready_i) begin
            pending_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b1;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/handshake_fork_1.sv
// Eager fork: replicates one valid/ready token onto SIZE outputs, each of
// which may accept in a different cycle; the input completes once all have.
module handshake_fork_1
   import handshake_fork_1_pkg::*;
#(
   parameter int unsigned DATA_TYPE = DEFAULT_DATA_TYPE,
   parameter int unsigned SIZE      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_TYPE-1:0]      ins,
   input  logic                      ins_valid,
   output logic                      ins_ready,
   output logic [SIZE*DATA_TYPE-1:0] outs,
   output logic [SIZE-1:0]           outs_valid,
   input  logic [SIZE-1:0]           outs_ready
);

   logic [SIZE-1:0] stall;

   // ins_ready depends only on registered state and outs_ready, never on
   // ins_valid, so no combinational path loops back to the producer.
   assign ins_ready = ~|stall;

   for (genvar gi = 0; gi < SIZE; gi++) begin : g_out
      eager_fork_register_block u_reg (
         .clk         (clk),
         .rst         (rst),
         .ins_valid_i (ins_valid),
         .ins_ready_i (ins_ready),
         .out_ready_i (outs_ready[gi]),
         .out_valid_o (outs_valid[gi]),
         .stall_o     (stall[gi])
      );

      assign outs[gi*DATA_TYPE +: DATA_TYPE] = ins;
   end

endmodule

// File: tb/tb_handshake_fork_1.sv
// Directed and scoreboarded checks of the eager fork at SIZE 2, 3 and 4.
module tb_handshake_fork_1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ins2 = '0;
   logic        valid2 = 1'b0;
   logic        ready2_o;
   logic [63:0] outs2;
   logic [1:0]  ov2;
   logic [1:0]  or2 = '0;

   logic [31:0] ins3 = '0;
   logic        valid3 = 1'b0;
   logic        ready3_o;
   logic [95:0] outs3;
   logic [2:0]  ov3;
   logic [2:0]  or3 = '0;

   logic [31:0]  ins4 = '0;
   logic         valid4 = 1'b0;
   logic         ready4_o;
   logic [127:0] outs4;
   logic [3:0]   ov4;
   logic [3:0]   or4 = '0;

   handshake_fork_1 #(.DATA_TYPE(32), .SIZE(2)) dut2 (
      .clk(clk), .rst(rst), .ins(ins2), .ins_valid(valid2), .ins_ready(ready2_o),
      .outs(outs2), .outs_valid(ov2), .outs_ready(or2));

   handshake_fork_1 #(.DATA_TYPE(32), .SIZE(3)) dut3 (
      .clk(clk), .rst(rst), .ins(ins3), .ins_valid(valid3), .ins_ready(ready3_o),
      .outs(outs3), .outs_valid(ov3), .outs_ready(or3));

   handshake_fork_1 #(.DATA_TYPE(32), .SIZE(4)) dut4 (
      .clk(clk), .rst(rst), .ins(ins4), .ins_valid(valid4), .ins_ready(ready4_o),
      .outs(outs4), .outs_valid(ov4), .outs_ready(or4));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk2(input string name, input logic [1:0] exp_ov, input logic exp_ir,
                       input logic [31:0] exp_d);
      #1;
      checks++;
      if (ov2 !== exp_ov || ready2_o !== exp_ir || outs2 !== {exp_d, exp_d}) begin
         failures++;
         $display("FAIL %s: outs_valid=%b ins_ready=%b outs=%h, expected %b %b %h",
                  name, ov2, ready2_o, outs2, exp_ov, exp_ir, {exp_d, exp_d});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; valid2 = 1'b1; or2 = 2'b00; ins2 = 32'h1234;
      #2;
      chk2("reset_valid", 2'b11, 1'b0, 32'h1234);
      step();
      rst = 1'b0;
      or2 = 2'b11;
      chk2("reset_ready_comb", 2'b11, 1'b1, 32'h1234);
      valid2 = 1'b0;
      step();
   endtask

   task automatic test_single();
      ins2 = 32'h5; valid2 = 1'b1; or2 = 2'b11;
      chk2("single_accept", 2'b11, 1'b1, 32'h5);
      step();
      ins2 = 32'h6;
      chk2("single_next_full", 2'b11, 1'b1, 32'h6);
      step();
   endtask

   task automatic test_staggered();
      ins2 = 32'hA; valid2 = 1'b1; or2 = 2'b01;
      chk2("stagger_c0", 2'b11, 1'b0, 32'hA);
      step();
      or2 = 2'b10;
      chk2("stagger_c1", 2'b10, 1'b1, 32'hA);
      step();
      ins2 = 32'hB; or2 = 2'b00;
      chk2("stagger_c2_rearmed", 2'b11, 1'b0, 32'hB);
      or2 = 2'b11;
      step();
   endtask

   task automatic test_backpressure();
      ins2 = 32'hDEAD_BEEF; valid2 = 1'b1; or2 = 2'b00;
      for (int c = 0; c < 4; c++) begin
         chk2($sformatf("bp_hold_%0d", c), 2'b11, 1'b0, 32'hDEAD_BEEF);
         step();
      end
      or2 = 2'b11;
      chk2("bp_release", 2'b11, 1'b1, 32'hDEAD_BEEF);
      step();
   endtask

   task automatic test_idle();
      valid2 = 1'b0; or2 = 2'b00; ins2 = 32'h7;
      chk2("idle_not_ready", 2'b00, 1'b0, 32'h7);
      or2 = 2'b11;
      chk2("idle_ready_indep", 2'b00, 1'b1, 32'h7);
      step();
   endtask

   task automatic test_async_reset();
      ins2 = 32'hC; valid2 = 1'b1; or2 = 2'b10;
      chk2("ar_partial", 2'b11, 1'b0, 32'hC);
      step();
      or2 = 2'b00;
      chk2("ar_pending01", 2'b01, 1'b0, 32'hC);
      #1;
      rst = 1'b1;
      chk2("ar_immediate", 2'b11, 1'b0, 32'hC);
      step();
      rst = 1'b0;
      chk2("ar_after", 2'b11, 1'b0, 32'hC);
      valid2 = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      or3 = 3'b111; valid3 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         ins3 = k;
         #1;
         checks++;
         if (ov3 !== 3'b111 || ready3_o !== 1'b1 ||
             outs3 !== {ins3, ins3, ins3} || outs3[31:0] !== k) begin
            failures++;
            $display("FAIL b2b_tok%0d: outs_valid=%b ins_ready=%b outs=%h, expected 111 1 data %0d",
                     k, ov3, ready3_o, outs3, k);
         end
         step();
      end
      valid3 = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] got;
      int tok, pulses, cycles;
      logic exp_ir;
      got = '0; tok = 0; pulses = 0; cycles = 0;
      valid4 = 1'b1;
      while (tok < 1000 && cycles < 20000) begin
         ins4 = 32'h1000 + tok;
         or4 = 4'($urandom_range(0, 15));
         #1;
         exp_ir = &(got | or4);
         checks++;
         if (ov4 !== ~got || ready4_o !== exp_ir) begin
            failures++;
            $display("FAIL rand_tok%0d: outs_valid=%b ins_ready=%b, expected %b %b",
                     tok, ov4, ready4_o, ~got, exp_ir);
         end
         for (int i = 0; i < 4; i++) begin
            if (ov4[i] && or4[i]) begin
               checks++;
               if (outs4[i*32 +: 32] !== 32'h1000 + tok || got[i]) begin
                  failures++;
                  $display("FAIL rand_data out%0d: got %h dup=%b, expected %h",
                           i, outs4[i*32 +: 32], got[i], 32'h1000 + tok);
               end
               got[i] = 1'b1;
            end
         end
         if (ready4_o) begin
            pulses++;
            checks++;
            if (got !== 4'b1111) begin
               failures++;
               $display("FAIL rand_complete tok%0d: accepted=%b, expected 1111", tok, got);
            end
            got = '0;
            tok++;
         end
         step();
         cycles++;
      end
      valid4 = 1'b0;
      checks++;
      if (pulses != 1000) begin
         failures++;
         $display("FAIL rand_pulses: got %0d, expected 1000 (cycles=%0d)", pulses, cycles);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_staggered();
      test_backpressure();
      test_idle();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
